// File: rtl/usb_wire_pkg.sv
// ---------------------------------------------------------------------------
// usb_wire_pkg
// Shared types, line-state constants and helper functions for the USB wire
// bus model (usb_wire_bus) and its line timers.
//   - bus_state_e     : ownership FSM encoding
//   - LS_*            : decoded line-state codes driven on lineState
//   - FS_J/FS_K/SE0/SE1 : raw {VP,VM} wire patterns
//   - popcount16      : number of set bits in a 16-bit enable vector
//   - lowest_index16  : index of the lowest set bit (0 when none set)
//   - pull_value      : idle wire level produced by the pullup resistors
//   - decode_line     : {VP,VM} + speed -> line-state code
// ---------------------------------------------------------------------------
package usb_wire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OWNED      = 2'd1,
    ST_TURNAROUND = 2'd2,
    ST_CONTENTION = 2'd3
  } bus_state_e;

  // Decoded line states
  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  // Raw {VP,VM} patterns (J/K given for full speed; low speed swaps them)
  localparam logic [1:0] FS_J = 2'b10;
  localparam logic [1:0] FS_K = 2'b01;
  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] SE1  = 2'b11;

  // Upper bound on the number of agents the helpers are sized for
  localparam int MAX_PORTS = 16;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic logic [3:0] lowest_index16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [1:0] pull_value(input logic dp_any, input logic dm_any);
    logic [1:0] pv;
    case ({dp_any, dm_any})
      2'b10:   pv = FS_J;
      2'b01:   pv = FS_K;
      2'b11:   pv = SE1;
      default: pv = SE0;
    endcase
    return pv;
  endfunction

  function automatic logic [1:0] decode_line(input logic [1:0] w, input logic fs);
    logic [1:0] ls;
    case (w)
      SE0:     ls = LS_SE0;
      SE1:     ls = LS_SE1;
      FS_J:    ls = fs ? LS_J : LS_K;
      FS_K:    ls = fs ? LS_K : LS_J;
      default: ls = LS_SE0;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_line_timer.sv
// ---------------------------------------------------------------------------
// usb_line_timer
// Saturating consecutive-cycle counter. Counts edges on which cond is high,
// clears on any edge where cond is low, and holds at THRESH. det is high
// exactly while the count sits at THRESH, so it rises on the same edge that
// registers the THRESH-th consecutive qualifying cycle.
// Ports:
//   clk_i  in  1  clock, rising edge
//   rst_i  in  1  synchronous active-high reset
//   cond   in  1  qualifying condition for this cycle
//   det    out 1  registered threshold-reached flag
// ---------------------------------------------------------------------------
module usb_line_timer
  import usb_wire_pkg::*;
#(
  parameter int THRESH = 480,
  parameter int CNT_W  = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cond,
  output logic det
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next count: clear on a break in the run, otherwise count up and saturate.
  always_comb begin
    cnt_next_s = ZERO_C;
    if (!cond) begin
      cnt_next_s = ZERO_C;
    end else if (cnt_r >= THRESH_C) begin
      cnt_next_s = THRESH_C;
    end else begin
      cnt_next_s = cnt_r + ONE_C;
    end
  end

  // Count and flag registers; the flag follows the count being registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= ZERO_C;
      det   <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      det   <= (cnt_next_s == THRESH_C);
    end
  end

endmodule

// File: rtl/usb_wire_bus.sv
// ---------------------------------------------------------------------------
// usb_wire_bus
// Registered, ownership-tracking resolver for a shared USB D+/D- pair with
// NUM_PORTS agents. Tracks which agent drives the wire, inserts a turnaround
// period after release, flags and counts contention, decodes the line state
// and detects long SE0 (bus reset) and long idle J (suspend).
// Every output reflects the inputs sampled on the previous rising edge.
// Ports:
//   clk_i         in  1            clock, rising edge
//   rst_i         in  1            synchronous active-high reset
//   drvEn         in  NUM_PORTS    per-port drive enable
//   drvData       in  2*NUM_PORTS  per-port {VP,VM}, port p at [2p+1:2p]
//   dPlusPullup   in  NUM_PORTS    per-port D+ pullup request
//   dMinusPullup  in  NUM_PORTS    per-port D- pullup request
//   wireData      out 2            resolved {VP,VM}
//   lineState     out 2            0=SE0 1=J 2=K 3=SE1
//   fullSpeed     out 1            D+ pulled up and D- not
//   owner         out OWNER_W      index of the current (or last) driver
//   ownerValid    out 1            bus is owned by a single driver
//   busResetDet   out 1            long SE0 seen
//   suspendDet    out 1            long idle J seen
//   contention    out 1            two or more drivers active
//   contentionCnt out 8            saturating count of contention entries
// ---------------------------------------------------------------------------
module usb_wire_bus
  import usb_wire_pkg::*;
#(
  parameter int NUM_PORTS         = 2,
  parameter int OWNER_W           = 4,
  parameter int TURNAROUND_CYCLES = 2,
  parameter int RESET_CYCLES      = 480,
  parameter int SUSPEND_CYCLES    = 144000,
  parameter int CNT_W             = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_PORTS-1:0]   drvEn,
  input  logic [2*NUM_PORTS-1:0] drvData,
  input  logic [NUM_PORTS-1:0]   dPlusPullup,
  input  logic [NUM_PORTS-1:0]   dMinusPullup,
  output logic [1:0]             wireData,
  output logic [1:0]             lineState,
  output logic                   fullSpeed,
  output logic [OWNER_W-1:0]     owner,
  output logic                   ownerValid,
  output logic                   busResetDet,
  output logic                   suspendDet,
  output logic                   contention,
  output logic [7:0]             contentionCnt
);

  localparam int TA_W = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam logic [TA_W-1:0] TA_LAST_C = TA_W'(TURNAROUND_CYCLES - 1);
  localparam logic [TA_W-1:0] TA_ZERO_C = {TA_W{1'b0}};
  localparam logic [TA_W-1:0] TA_ONE_C  = {{(TA_W-1){1'b0}}, 1'b1};

  bus_state_e        state_r;
  bus_state_e        state_next_s;
  logic [TA_W-1:0]   ta_cnt_r;
  logic [TA_W-1:0]   ta_next_s;
  logic [OWNER_W-1:0] owner_next_s;

  logic [15:0] en_ext_s;
  logic [4:0]  n_drv_s;
  logic [3:0]  drv_idx_s;
  logic        dp_any_s;
  logic        dm_any_s;
  logic [1:0]  pull_s;
  logic        fs_s;
  logic [1:0]  owner_data_s;
  logic [1:0]  wire_next_s;
  logic [1:0]  ls_next_s;
  logic        enter_cont_s;
  logic        reset_cond_s;
  logic        susp_cond_s;

  assign en_ext_s  = 16'(drvEn);
  assign n_drv_s   = popcount16(en_ext_s);
  assign drv_idx_s = lowest_index16(en_ext_s);
  assign dp_any_s  = |dPlusPullup;
  assign dm_any_s  = |dMinusPullup;
  assign pull_s    = pull_value(dp_any_s, dm_any_s);
  assign fs_s      = dp_any_s & ~dm_any_s;

  // Ownership FSM next state. Two or more drivers wins over everything;
  // a lone driver always takes (or keeps) ownership, even mid-turnaround.
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner;
    ta_next_s    = ta_cnt_r;
    if (n_drv_s >= 5'd2) begin
      state_next_s = ST_CONTENTION;
    end else if (n_drv_s == 5'd1) begin
      state_next_s = ST_OWNED;
      owner_next_s = OWNER_W'(drv_idx_s);
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_OWNED: begin
          state_next_s = ST_TURNAROUND;
          ta_next_s    = TA_ZERO_C;
        end
        ST_TURNAROUND: begin
          if (ta_cnt_r == TA_LAST_C) begin
            state_next_s = ST_IDLE;
          end else begin
            ta_next_s = ta_cnt_r + TA_ONE_C;
          end
        end
        ST_CONTENTION: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Select the next owner's {VP,VM}; owner indices are unique so OR-ing
  // the masked pairs yields exactly one port's data.
  always_comb begin
    owner_data_s = 2'b00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      owner_data_s = owner_data_s |
                     (drvData[2*p +: 2] & {2{owner_next_s == OWNER_W'(p)}});
    end
  end

  // Wire level for the state being entered.
  always_comb begin
    wire_next_s = pull_s;
    case (state_next_s)
      ST_OWNED:      wire_next_s = owner_data_s;
      ST_CONTENTION: wire_next_s = SE1;
      ST_IDLE:       wire_next_s = pull_s;
      ST_TURNAROUND: wire_next_s = pull_s;
      default:       wire_next_s = pull_s;
    endcase
  end

  assign ls_next_s    = decode_line(wire_next_s, fs_s);
  assign enter_cont_s = (state_next_s == ST_CONTENTION) && (state_r != ST_CONTENTION);
  assign reset_cond_s = (ls_next_s == LS_SE0);
  assign susp_cond_s  = (state_next_s == ST_IDLE) && (ls_next_s == LS_J);

  // FSM state plus all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      ta_cnt_r      <= TA_ZERO_C;
      owner         <= {OWNER_W{1'b0}};
      ownerValid    <= 1'b0;
      contention    <= 1'b0;
      contentionCnt <= 8'd0;
      wireData      <= SE0;
      lineState     <= LS_SE0;
      fullSpeed     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ta_cnt_r   <= ta_next_s;
      owner      <= owner_next_s;
      ownerValid <= (state_next_s == ST_OWNED);
      contention <= (state_next_s == ST_CONTENTION);
      if (enter_cont_s && (contentionCnt != 8'd255)) begin
        contentionCnt <= contentionCnt + 8'd1;
      end else begin
        contentionCnt <= contentionCnt;
      end
      wireData  <= wire_next_s;
      lineState <= ls_next_s;
      fullSpeed <= fs_s;
    end
  end

  usb_line_timer #(
    .THRESH (RESET_CYCLES),
    .CNT_W  (CNT_W)
  ) u_reset_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cond  (reset_cond_s),
    .det   (busResetDet)
  );

  usb_line_timer #(
    .THRESH (SUSPEND_CYCLES),
    .CNT_W  (CNT_W)
  ) u_suspend_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cond  (susp_cond_s),
    .det   (suspendDet)
  );

endmodule
